// File: rtl/cpu_pkg.sv
// Shared RV32I pipeline types: fetch FSM states, IF/ID bundle, reset constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        BUFFERED = 2'd1,
        DROP     = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Single-outstanding instruction-memory request/acknowledge port.
interface fetch_stage_if;

    logic        IReq;
    logic [31:0] IAddr;
    logic        IAck;
    logic [31:0] IRdata;

    modport master (
        output IReq,
        output IAddr,
        input  IAck,
        input  IRdata
    );

    modport slave (
        input  IReq,
        input  IAddr,
        output IAck,
        output IRdata
    );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds, bubble is NOP.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INSTR
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  stall,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    ifid_t bubble;

    assign bubble = '{instr: NOP, pc: '0, pcplus4: '0, valid: 1'b0};

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            q <= bubble;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC, request FSM, 1-entry stall buffer, IF/ID register.
// Optional FETCH_MISALIGN_EN adds MisalignD for unaligned redirect targets.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master imem,
    input  logic          StallD,
    input  logic          FlushD,
    input  logic          PCSrcE,
    input  logic [31:0]   PCTargetE,
    output logic [31:0]   InstrD,
    output logic [31:0]   PCD,
    output logic [31:0]   PCPlus4D,
    output logic          ValidD
`ifdef FETCH_MISALIGN_EN
    ,
    output logic          MisalignD
`endif
);

    import cpu_pkg::*;

    fetch_state_t state, state_n;
    logic [31:0]  pcf, pcf_n;
    logic [31:0]  redir, redir_n;
    logic [31:0]  bufi, bufi_n;
    logic [31:0]  bufpc, bufpc_n;
    logic [31:0]  tgt;
    logic         ack;
    logic         flush_d;
    ifid_t        d, q;

    assign tgt        = PCTargetE & 32'hFFFF_FFFC;
    assign imem.IReq  = !reset && (state != BUFFERED);
    assign imem.IAddr = pcf;
    assign ack        = imem.IReq && imem.IAck;
    assign flush_d    = FlushD || PCSrcE;

    always_comb begin
        state_n = state;
        pcf_n   = pcf;
        redir_n = redir;
        bufi_n  = bufi;
        bufpc_n = bufpc;
        d       = '{instr: NOP_INSTR, pc: '0, pcplus4: '0, valid: 1'b0};
        unique case (1'b1)
            (state == FETCH): begin
                if (PCSrcE) begin
                    if (ack) begin
                        pcf_n = tgt;
                    end else begin
                        redir_n = tgt;
                        state_n = DROP;
                    end
                end else if (ack) begin
                    pcf_n = pcf + 32'd4;
                    if (StallD) begin
                        bufi_n  = imem.IRdata;
                        bufpc_n = pcf;
                        state_n = BUFFERED;
                    end else begin
                        d = '{instr: imem.IRdata, pc: pcf,
                              pcplus4: pcf + 32'd4, valid: 1'b1};
                    end
                end
            end
            (state == BUFFERED): begin
                if (PCSrcE) begin
                    pcf_n   = tgt;
                    state_n = FETCH;
                end else if (!StallD) begin
                    d = '{instr: bufi, pc: bufpc,
                          pcplus4: bufpc + 32'd4, valid: 1'b1};
                    state_n = FETCH;
                end
            end
            default: begin
                // Old request must still complete; its data is thrown away.
                if (PCSrcE) begin
                    if (ack) begin
                        pcf_n   = tgt;
                        state_n = FETCH;
                    end else begin
                        redir_n = tgt;
                    end
                end else if (ack) begin
                    pcf_n   = redir;
                    state_n = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pcf   <= RESET_PC;
            redir <= '0;
            bufi  <= NOP_INSTR;
            bufpc <= '0;
        end else begin
            state <= state_n;
            pcf   <= pcf_n;
            redir <= redir_n;
            bufi  <= bufi_n;
            bufpc <= bufpc_n;
        end
    end

    ifid_reg #(.NOP(NOP_INSTR)) u_ifid (
        .clk   (clk),
        .reset (reset),
        .stall (StallD),
        .flush (flush_d),
        .d     (d),
        .q     (q)
    );

    assign InstrD   = q.instr;
    assign PCD      = q.pc;
    assign PCPlus4D = q.pcplus4;
    assign ValidD   = q.valid;

`ifdef FETCH_MISALIGN_EN
    logic pmis, rmis, bmis, mq;

    // pmis tags the word at pcf; it follows pcf through DROP and the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            pmis <= 1'b0;
            rmis <= 1'b0;
            bmis <= 1'b0;
            mq   <= 1'b0;
        end else begin
            if (PCSrcE && state_n == DROP) begin
                rmis <= |PCTargetE[1:0];
            end
            if (PCSrcE && state_n == FETCH) begin
                pmis <= |PCTargetE[1:0];
            end else if (ack && state == DROP) begin
                pmis <= rmis;
            end else if (ack) begin
                pmis <= 1'b0;
            end
            if (state == FETCH && state_n == BUFFERED) begin
                bmis <= pmis;
            end
            if (flush_d) begin
                mq <= 1'b0;
            end else if (!StallD) begin
                mq <= d.valid && ((state == BUFFERED) ? bmis : pmis);
            end
        end
    end

    assign MisalignD = mq;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized self-checking bench for fetch_stage.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
    logic        ack_tb;
`ifdef FETCH_MISALIGN_EN
    logic        MisalignD;
`endif

    int tests = 0;
    int fails = 0;

    fetch_stage_if mif ();

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return {a[15:0], a[15:0]} ^ 32'h5A5A_0013;
    endfunction

    assign mif.IRdata = memword(mif.IAddr);
    assign mif.IAck   = ack_tb;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .imem      (mif),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
`ifdef FETCH_MISALIGN_EN
        ,
        .MisalignD (MisalignD)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic run_to(input logic [31:0] a);
        int n = 0;
        while (mif.IAddr !== a && n < 40) begin
            tick();
            n++;
        end
        chk("reach_addr", mif.IAddr, a);
    endtask

    logic        pst, pfl, prd, preq, pack;
    logic [31:0] ptgt, paddr;
    logic [31:0] s_i, s_p, s_p4;
    logic        s_v, s_m, exp_mis;
    logic [31:0] exp_pc;
    int          nvalid;

    initial begin
        reset = 1'b1; ack_tb = 1'b0; StallD = 1'b0;
        FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        tick(); tick();
        chk("rst_ireq", mif.IReq, 0);
        chk("rst_valid", ValidD, 0);
        chk("rst_instr", InstrD, NOP);
        chk("rst_pcd", PCD, 0);
        chk("rst_pc4", PCPlus4D, 0);
`ifdef FETCH_MISALIGN_EN
        chk("rst_mis", MisalignD, 0);
`endif
        reset = 1'b0;
        #1;
        chk("first_ireq", mif.IReq, 1);
        chk("first_addr", mif.IAddr, 0);

        // back-to-back fetch with same-cycle ack
        ack_tb = 1'b1;
        tick();
        chk("t1_instr", InstrD, 32'h0050_0093);
        chk("t1_pcd", PCD, 0);
        chk("t1_valid", ValidD, 1);
        chk("t1_addr4", mif.IAddr, 4);
        tick();
        chk("t1_instr2", InstrD, 32'h00A0_0113);
        chk("t1_pcd2", PCD, 4);
        chk("t1_addr8", mif.IAddr, 8);

        // delayed ack at 0x10
        run_to(32'h10);
        ack_tb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_req", mif.IReq, 1);
            chk("t2_addr", mif.IAddr, 32'h10);
            chk("t2_bubble", ValidD, 0);
        end
        ack_tb = 1'b1;
        tick();
        chk("t2_instr", InstrD, memword(32'h10));
        chk("t2_pcd", PCD, 32'h10);
        chk("t2_valid", ValidD, 1);

        // stall while ack at 0x20
        run_to(32'h20);
        StallD = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t3_req", mif.IReq, 0);
            chk("t3_hold_pcd", PCD, 32'h1C);
            chk("t3_hold_i", InstrD, memword(32'h1C));
        end
        StallD = 1'b0;
        tick();
        chk("t3_instr", InstrD, memword(32'h20));
        chk("t3_pcd", PCD, 32'h20);
        chk("t3_next", mif.IAddr, 32'h24);

        // redirect while request at 0x30 outstanding
        run_to(32'h30);
        ack_tb = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h100;
        tick();
        chk("t4_flush", ValidD, 0);
        chk("t4_addr", mif.IAddr, 32'h30);
        chk("t4_req", mif.IReq, 1);
        PCSrcE = 1'b0;
        tick();
        chk("t4_addr2", mif.IAddr, 32'h30);
        chk("t4_valid2", ValidD, 0);
        ack_tb = 1'b1;
        tick();
        chk("t4_drop", ValidD, 0);
        chk("t4_next", mif.IAddr, 32'h100);
        tick();
        chk("t4_pcd", PCD, 32'h100);
        chk("t4_instr", InstrD, memword(32'h100));

        // redirect plus stall while buffered
        StallD = 1'b1;
        tick();
        chk("t5_buf_req", mif.IReq, 0);
        PCSrcE = 1'b1; PCTargetE = 32'h200;
        tick();
        chk("t5_valid", ValidD, 0);
        chk("t5_instr", InstrD, NOP);
        chk("t5_addr", mif.IAddr, 32'h200);
        chk("t5_req", mif.IReq, 1);
        PCSrcE = 1'b0; StallD = 1'b0;
        tick();
        chk("t5_pcd", PCD, 32'h200);

        // FlushD alone leaves PC and request alone
        ack_tb = 1'b0; FlushD = 1'b1;
        tick();
        chk("t6_valid", ValidD, 0);
        chk("t6_addr", mif.IAddr, 32'h204);
        FlushD = 1'b0; ack_tb = 1'b1;
        tick();
        chk("t6_pcd", PCD, 32'h204);

        // PC wrap
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        tick();
        chk("t7_addr", mif.IAddr, 32'hFFFF_FFFC);
        chk("t7_valid", ValidD, 0);
        PCSrcE = 1'b0;
        tick();
        chk("t7_pcd", PCD, 32'hFFFF_FFFC);
        chk("t7_pc4", PCPlus4D, 0);
        chk("t7_next", mif.IAddr, 0);

        // unaligned redirect target
        PCSrcE = 1'b1; PCTargetE = 32'h102;
        tick();
        chk("t8_addr", mif.IAddr, 32'h100);
        PCSrcE = 1'b0;
        tick();
        chk("t8_pcd", PCD, 32'h100);
        chk("t8_valid", ValidD, 1);
`ifdef FETCH_MISALIGN_EN
        chk("t8_mis", MisalignD, 1);
`endif
        tick();
        chk("t8_pcd2", PCD, 32'h104);
`ifdef FETCH_MISALIGN_EN
        chk("t8_mis2", MisalignD, 0);
`endif

        // reset during outstanding request
        ack_tb = 1'b0;
        tick();
        chk("t9_pending", mif.IReq, 1);
        reset = 1'b1;
        #1;
        chk("t9_req_drop", mif.IReq, 0);
        tick();
        chk("t9_valid", ValidD, 0);
        chk("t9_instr", InstrD, NOP);
        chk("t9_pcd", PCD, 0);
        reset = 1'b0;
        #1;
        chk("t9_addr", mif.IAddr, 0);
        chk("t9_req", mif.IReq, 1);

        // randomized run against an in-order program-stream model
        exp_pc = 0; exp_mis = 1'b0; nvalid = 0;
        pst = 0; pfl = 0; prd = 0; preq = 0; pack = 0;
        ptgt = 0; paddr = 0;
        s_i = 0; s_p = 0; s_p4 = 0; s_v = 0; s_m = 0;
        for (int c = 0; c < 3000; c++) begin
            if (prd || pfl) begin
                chk("r_flush_v", ValidD, 0);
                chk("r_flush_i", InstrD, NOP);
`ifdef FETCH_MISALIGN_EN
                chk("r_flush_m", MisalignD, 0);
`endif
            end else if (pst) begin
                chk("r_hold_i", InstrD, s_i);
                chk("r_hold_p", PCD, s_p);
                chk("r_hold_p4", PCPlus4D, s_p4);
                chk("r_hold_v", ValidD, s_v);
`ifdef FETCH_MISALIGN_EN
                chk("r_hold_m", MisalignD, s_m);
`endif
            end else if (ValidD) begin
                chk("r_pc", PCD, exp_pc);
                chk("r_instr", InstrD, memword(exp_pc));
                chk("r_pc4", PCPlus4D, exp_pc + 32'd4);
`ifdef FETCH_MISALIGN_EN
                chk("r_mis", MisalignD, exp_mis);
`endif
                exp_mis = 1'b0;
                exp_pc += 32'd4;
                nvalid++;
            end
            if (prd) begin
                exp_pc  = ptgt & 32'hFFFF_FFFC;
                exp_mis = |ptgt[1:0];
            end
            if (preq && !pack) begin
                chk("r_hs_req", mif.IReq, 1);
                chk("r_hs_addr", mif.IAddr, paddr);
            end
            StallD    = ($urandom % 4) == 0;
            ack_tb    = ($urandom % 3) != 0;
            PCSrcE    = ($urandom % 10) == 0;
            FlushD    = StallD && (($urandom % 3) == 0);
            PCTargetE = $urandom & 32'h0000_0FFF;
            pst = StallD; pfl = FlushD; prd = PCSrcE; ptgt = PCTargetE;
            preq = mif.IReq; paddr = mif.IAddr;
            pack = mif.IReq && ack_tb;
            s_i = InstrD; s_p = PCD; s_p4 = PCPlus4D; s_v = ValidD;
`ifdef FETCH_MISALIGN_EN
            s_m = MisalignD;
`endif
            tick();
        end
        chk("r_progress", nvalid > 300, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
